univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, the general-purpose successor to the 4-bit serial-in/serial-out register. It supports hold, bidirectional shift, rotate, parallel load and clear, with serial taps at both ends and a full parallel output. A built-in shift counter flags each time WIDTH bits have moved since the last load or clear, so downstream serialiser/deserialiser logic can frame words without an external counter.

Parameters:
WIDTH, 8, register width in bits; legal range 2 to 64.
RESET_VAL, 0, value loaded into the register on reset; WIDTH bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  clock enable; when low, every register holds its value.
mode  input  3  operation select; sampled on an edge only when en=1.
sin_r  input  1  serial input that enters the MSB on shift-right.
sin_l  input  1  serial input that enters the LSB on shift-left.
pin  input  WIDTH  parallel load data.
pout  output  WIDTH  register contents q.
sout_r  output  1  q[0], the right-shift serial output.
sout_l  output  1  q[WIDTH-1], the left-shift serial output.
cnt  output  CW  shift count since the last load, clear or wrap; CW = max(1, clog2(WIDTH)).
frame_done  output  1  one-cycle pulse after WIDTH shift or rotate operations.

Behaviour:
- Reset: rst=1 at a rising edge sets q=RESET_VAL, cnt=0 and frame_done=0. Reset has priority over en and mode. Asserting reset mid-frame discards the partial count.
- en=0: q and cnt hold; frame_done=0 on that edge.
- Operations with en=1, applied on the rising edge:
  - 000 hold: q and cnt unchanged.
  - 001 shift right: q <= {sin_r, q[WIDTH-1:1]}; cnt advances.
  - 010 shift left: q <= {q[WIDTH-2:0], sin_l}; cnt advances.
  - 011 parallel load: q <= pin; cnt <= 0.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}; cnt advances.
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; cnt advances.
  - 110 clear: q <= 0; cnt <= 0 (not RESET_VAL).
  - 111 reserved: behaves as hold.
- Counter advance rule: if cnt == WIDTH-1, then cnt <= 0 and frame_done <= 1. Otherwise cnt <= cnt+1 and frame_done <= 0.
- frame_done is registered. It is high for exactly the one cycle following the WIDTH-th shift or rotate. It is 0 after any hold, load, clear, reserved mode or en=0 edge.
- The direction may change mid-frame. Shift and rotate operations share one count, whichever direction is used.
- Outputs: pout, sout_r and sout_l are driven directly from q with no combinational path from the inputs.
- Latency: a bit presented on sin_r appears on sout_r after exactly WIDTH enabled shift-right edges. This gives the original serial-in/serial-out behaviour at generic width.
- Timing of load: pout reflects pin one cycle after the load edge.
- The block contains no combinational loops and no latches.

Test Plan:
1. WIDTH=8: rst=1 for one edge -> pout=0x00, cnt=0, frame_done=0. With RESET_VAL=0xA5 -> pout=0xA5.
2. SISO check: mode=001, en=1, sin_r stream 1,0,1,1,0,0,1,0 -> after 8 edges pout=0x4D; sout_r shows the first bit (1) only after the 8th edge; frame_done=1 for exactly the cycle after the 8th edge with cnt=0.
3. Load 0x81 then mode=100 for 1 edge -> pout=0xC0. Then mode=101 for 2 edges -> 0x03. Then 8 further rotate-right edges -> frame_done pulses once.
4. Load 0xF0, mode=010 with sin_l=1 for 3 edges -> pout=0x87 and cnt=3. Toggle en=0 for 5 cycles -> pout and cnt unchanged, frame_done=0.
5. Shift 5 times, then mode=110 -> pout=0x00, cnt=0. A further 7 shifts give no frame_done; the 8th shift gives frame_done.
6. Shift 4 times, then rst=1 together with mode=011, pin=0xFF -> reset wins: pout=RESET_VAL, cnt=0. mode=111 for 2 edges -> no change.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift and rotate in either direction,
// parallel load and clear, with serial taps at both ends. A shared shift
// counter raises frame_done for one cycle each time WIDTH bits have moved
// since the last load, clear or wrap.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_next;
  logic             done_q;
  logic             done_next;
  logic             advance;

  // Next-state selection for an enabled edge; shifts and rotates all share
  // one counter so a frame may mix directions freely.
  always_comb begin
    q_next    = q;
    cnt_next  = cnt_q;
    done_next = 1'b0;
    advance   = 1'b0;
    case (mode)
      MODE_SHR: begin
        q_next  = {sin_r, q[WIDTH-1:1]};
        advance = 1'b1;
      end
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], sin_l};
        advance = 1'b1;
      end
      MODE_LOAD: begin
        q_next   = pin;
        cnt_next = '0;
      end
      MODE_ROTR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        advance = 1'b1;
      end
      MODE_ROTL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        advance = 1'b1;
      end
      MODE_CLEAR: begin
        q_next   = '0;
        cnt_next = '0;
      end
      default: begin
        q_next = q;
      end
    endcase
    if (advance) begin
      if (cnt_q == CNT_LAST) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next  = cnt_q + CW'(1);
      end
    end
  end

  // State register: synchronous reset wins over everything, and a disabled
  // edge holds data and count while dropping the frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      q      <= q_next;
      cnt_q  <= cnt_next;
      done_q <= done_next;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign pout       = q;
  assign sout_r     = q[0];
  assign sout_l     = q[WIDTH-1];
  assign cnt        = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg at WIDTH=8. Each driven edge pushes the expected
// register state onto a scoreboard queue, which is popped and compared
// against the DUT just after the edge.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst, en, sin_r, sin_l;
  logic [2:0]   mode;
  logic [W-1:0] pin;
  logic [W-1:0] pout, pout0;
  logic         sout_r, sout_l, sout_r0, sout_l0;
  logic [2:0]   cnt, cnt0;
  logic         frame_done, frame_done0;

  typedef struct {
    logic [W-1:0] q;
    logic [2:0]   cnt;
    logic         done;
  } exp_t;

  exp_t sbq[$];

  logic [W-1:0] m_q;
  logic [2:0]   m_cnt;
  logic         m_done;

  int err_count = 0;
  int check_count = 0;
  int pulses;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .pout(pout), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt),
    .frame_done(frame_done)
  );

  univ_shift_reg #(.WIDTH(W)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .pout(pout0), .sout_r(sout_r0), .sout_l(sout_l0), .cnt(cnt0),
    .frame_done(frame_done0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one edge of the given inputs.
  task automatic modelStep(input logic r, input logic e, input logic [2:0] m,
                           input logic sr, input logic sl, input logic [W-1:0] p);
    logic adv;
    adv = 1'b0;
    if (r) begin
      m_q = RV; m_cnt = 3'd0; m_done = 1'b0;
    end else if (!e) begin
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m)
        3'b001: begin m_q = {sr, m_q[W-1:1]}; adv = 1'b1; end
        3'b010: begin m_q = {m_q[W-2:0], sl}; adv = 1'b1; end
        3'b011: begin m_q = p; m_cnt = 3'd0; end
        3'b100: begin m_q = {m_q[0], m_q[W-1:1]}; adv = 1'b1; end
        3'b101: begin m_q = {m_q[W-2:0], m_q[W-1]}; adv = 1'b1; end
        3'b110: begin m_q = '0; m_cnt = 3'd0; end
        default: ;
      endcase
      if (adv) begin
        if (m_cnt == 3'd7) begin
          m_cnt = 3'd0; m_done = 1'b1;
        end else begin
          m_cnt = m_cnt + 3'd1;
        end
      end
    end
  endtask

  // Drive one edge's inputs, queue the expected state, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m,
                               input logic sr, input logic sl, input logic [W-1:0] p);
    exp_t ex;
    @(negedge clk);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
    modelStep(r, e, m, sr, sl, p);
    sbq.push_back('{q: m_q, cnt: m_cnt, done: m_done});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
    end else begin
      ex = sbq.pop_front();
      checkOutput("sb_pout", pout, ex.q);
      checkOutput("sb_cnt", cnt, ex.cnt);
      checkOutput("sb_done", frame_done, ex.done);
      checkOutput("sb_sout_r", sout_r, ex.q[0]);
      checkOutput("sb_sout_l", sout_l, ex.q[W-1]);
    end
  endtask

  logic [7:0] siso_bits;

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0; pin = '0;
    m_q = '0; m_cnt = '0; m_done = 1'b0;

    // Reset state of both instances
    applyStimulus(1, 0, 3'b000, 0, 0, 8'h00);
    checkOutput("rst_pout_a5", pout, 8'hA5);
    checkOutput("rst_pout_00", pout0, 8'h00);
    checkOutput("rst_cnt", cnt, 0);
    checkOutput("rst_done", frame_done, 0);

    // Serial-in/serial-out from a cleared register
    applyStimulus(0, 1, 3'b110, 0, 0, 8'h00);
    siso_bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'b001, siso_bits[i], 0, 8'h00);
      if (i == 6) checkOutput("siso_sout_r_early", sout_r, 0);
    end
    checkOutput("siso_pout", pout, 8'h4D);
    checkOutput("siso_sout_r", sout_r, 1);
    checkOutput("siso_done", frame_done, 1);
    checkOutput("siso_cnt", cnt, 0);
    applyStimulus(0, 1, 3'b000, 0, 0, 8'h00);
    checkOutput("siso_done_drop", frame_done, 0);

    // Rotations
    applyStimulus(0, 1, 3'b011, 0, 0, 8'h81);
    applyStimulus(0, 1, 3'b100, 0, 0, 8'h00);
    checkOutput("rotr_pout", pout, 8'hC0);
    applyStimulus(0, 1, 3'b101, 0, 0, 8'h00);
    applyStimulus(0, 1, 3'b101, 0, 0, 8'h00);
    checkOutput("rotl_pout", pout, 8'h03);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'b100, 0, 0, 8'h00);
      if (frame_done) pulses++;
    end
    checkOutput("rot_pulses", pulses, 1);

    // Shift left then hold with en low
    applyStimulus(0, 1, 3'b011, 0, 0, 8'hF0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3'b010, 0, 1, 8'h00);
    checkOutput("shl_pout", pout, 8'h87);
    checkOutput("shl_cnt", cnt, 3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 3'b001, 1, 1, 8'hFF);
    checkOutput("en0_pout", pout, 8'h87);
    checkOutput("en0_cnt", cnt, 3);
    checkOutput("en0_done", frame_done, 0);

    // Clear discards the partial count
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 3'b001, 1, 0, 8'h00);
    applyStimulus(0, 1, 3'b110, 0, 0, 8'h00);
    checkOutput("clr_pout", pout, 8'h00);
    checkOutput("clr_cnt", cnt, 0);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 3'b010, 0, 1, 8'h00);
      if (frame_done) pulses++;
    end
    checkOutput("clr_no_early_done", pulses, 0);
    applyStimulus(0, 1, 3'b010, 0, 1, 8'h00);
    checkOutput("clr_done_8th", frame_done, 1);

    // Reset beats a simultaneous load; reserved mode holds
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 3'b001, 0, 0, 8'h00);
    applyStimulus(1, 1, 3'b011, 0, 0, 8'hFF);
    checkOutput("rst_wins_pout", pout, 8'hA5);
    checkOutput("rst_wins_cnt", cnt, 0);
    applyStimulus(0, 1, 3'b111, 1, 1, 8'h00);
    applyStimulus(0, 1, 3'b111, 1, 1, 8'h00);
    checkOutput("rsvd_pout", pout, 8'hA5);
    checkOutput("rsvd_cnt", cnt, 0);

    // Random mix of operations against the model
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
